// File: rtl/gray_mem_arb.sv
// gray_mem_arb: two-requester round-robin read arbiter in front of a single-port
// gray-pixel memory (14-bit {row,col} address, 8-bit data).
//
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   req0/req1, addr0/addr1        read requests, held with their address until granted
//   gnt0/gnt1                     combinational grant: the address goes to memory this cycle
//   rvalid0/rvalid1, rdata0/rdata1 read return one cycle after the grant; rdata holds otherwise
//   mem_cs, mem_we, mem_addr, mem_wdata, mem_rdata
//                                 memory port; mem_rdata is valid the cycle after mem_cs
//   host_we, host_addr, host_wdata only with ARB_HOSTWR_EN defined: a host write that
//                                 steals the memory cycle and freezes arbitration
//
// Parameter MAX_BURST: consecutive grants to one owner before the other requester is
// given the memory (default 9, one 3x3 window). Must lie in 1..15.
// Build option: define ARB_HOSTWR_EN to add the host write port.
module gray_mem_arb #(
  parameter int unsigned MAX_BURST = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [13:0] addr0,
  input  logic [13:0] addr1,
`ifdef ARB_HOSTWR_EN
  input  logic        host_we,
  input  logic [13:0] host_addr,
  input  logic [7:0]  host_wdata,
`endif
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;             // grants given in the current burst
  logic       rr_q;              // 0: favour req0 on a tie, 1: favour req1
  logic       inflight_valid_q;  // a read was issued last cycle
  logic       inflight_owner_q;  // 0: req0 issued it, 1: req1
  logic [7:0] rdata0_q;
  logic [7:0] rdata1_q;
  logic       hw_active;

`ifdef ARB_HOSTWR_EN
  assign hw_active = host_we & ~reset;
`else
  assign hw_active = 1'b0;
`endif

  // Grants are decided combinationally so an idle arbiter serves a request at once.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !hw_active) begin
      case (state_q)
        StIdle: begin
          if (req0 && (!req1 || !rr_q)) gnt0 = 1'b1;
          else if (req1)                gnt1 = 1'b1;
        end
        StOwn0:  gnt0 = req0;
        StOwn1:  gnt1 = req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_cs    = gnt0 | gnt1 | hw_active;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0)      mem_addr = addr0;
    else if (gnt1) mem_addr = addr1;
`ifdef ARB_HOSTWR_EN
    if (hw_active) begin
      mem_we    = 1'b1;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
`endif
  end

  // Memory data arrives the cycle after the grant; pass it straight through and keep a copy
  // so rdata holds between returns. Reset squashes a return that was still in flight.
  assign rvalid0 = inflight_valid_q & ~inflight_owner_q & ~reset;
  assign rvalid1 = inflight_valid_q &  inflight_owner_q & ~reset;
  assign rdata0  = rvalid0 ? mem_rdata : rdata0_q;
  assign rdata1  = rvalid1 ? mem_rdata : rdata1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      rr_q             <= 1'b0;
      inflight_valid_q <= 1'b0;
      inflight_owner_q <= 1'b0;
      rdata0_q         <= '0;
      rdata1_q         <= '0;
    end else begin
      inflight_valid_q <= gnt0 | gnt1;
      inflight_owner_q <= gnt1;
      if (rvalid0) rdata0_q <= mem_rdata;
      if (rvalid1) rdata1_q <= mem_rdata;

      // A host write cycle leaves state, counter and pointer untouched.
      if (!hw_active) begin
        if (gnt0 || gnt1) begin
          rr_q <= gnt0;  // the requester just served loses the next tie
          if (cnt_q == BurstLast) begin
            cnt_q <= '0;
            if (gnt0 && req1)      state_q <= StOwn1;
            else if (gnt1 && req0) state_q <= StOwn0;
            else                   state_q <= gnt0 ? StOwn0 : StOwn1;
          end else begin
            cnt_q   <= cnt_q + 4'd1;
            state_q <= gnt0 ? StOwn0 : StOwn1;
          end
        end else if (state_q != StIdle) begin
          // Owner dropped its request: hand over or go idle, burst restarts.
          cnt_q <= '0;
          if (state_q == StOwn0 && req1)      state_q <= StOwn1;
          else if (state_q == StOwn1 && req0) state_q <= StOwn0;
          else                                state_q <= StIdle;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_mem_arb.sv
// tb_gray_mem_arb: directed stimulus for gray_mem_arb with a behavioural model
// (owner / burst count / tie favourite) checked every cycle, plus literal expectations.
// Host write scenarios are built only when ARB_HOSTWR_EN is defined.
module tb_gray_mem_arb;

  localparam int MaxB = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [13:0] addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata0, rdata1;
  logic        mem_cs, mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
`ifdef ARB_HOSTWR_EN
  logic        host_we;
  logic [13:0] host_addr;
  logic [7:0]  host_wdata;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gray_mem_arb #(.MAX_BURST(MaxB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .addr0      (addr0),
    .addr1      (addr1),
`ifdef ARB_HOSTWR_EN
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
`endif
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous memory: read data appears the cycle after mem_cs.
  logic [7:0] mem [0:16383];
  initial for (int i = 0; i < 16384; i++) mem[i] = 8'((i * 7 + 3) & 255);
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_owner = -1;  // -1 none, else requester index holding the burst
  int         m_cnt   = 0;
  int         m_fav   = 0;   // requester that wins an idle tie
  int         m_pend  = -1;  // requester whose read returns this cycle
  logic [7:0] m_pdata = 8'h00;
  logic [7:0] m_last [2];
  logic       r [2];
  logic [13:0] a [2];
  logic       hw;
  logic [13:0] e_addr;
  logic [7:0]  e_wdata;
  int         who;

  always @(negedge clk) begin
    r[0] = req0; r[1] = req1; a[0] = addr0; a[1] = addr1;
    hw = 1'b0;
    e_wdata = 8'h00;
`ifdef ARB_HOSTWR_EN
    hw = host_we;
    e_wdata = hw ? host_wdata : 8'h00;
`endif
    if (reset) begin
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_rvalid0", rvalid0, 0);
      check("rst_rvalid1", rvalid1, 0);
      m_owner = -1; m_cnt = 0; m_fav = 0; m_pend = -1;
      m_last[0] = 8'h00; m_last[1] = 8'h00;
    end else begin
      who = -1;
      if (!hw) begin
        if (m_owner < 0) begin
          if (r[0] && r[1]) who = m_fav;
          else if (r[0])    who = 0;
          else if (r[1])    who = 1;
        end else if (r[m_owner]) begin
          who = m_owner;
        end
      end
      e_addr = hw ? (
`ifdef ARB_HOSTWR_EN
                     host_addr
`else
                     14'd0
`endif
                    ) : (who >= 0 ? a[who] : 14'd0);
      check("gnt0", gnt0, who == 0);
      check("gnt1", gnt1, who == 1);
      check("mem_cs", mem_cs, hw || who >= 0);
      check("mem_we", mem_we, hw);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      if (m_pend >= 0) m_last[m_pend] = m_pdata;
      check("rvalid0", rvalid0, m_pend == 0);
      check("rvalid1", rvalid1, m_pend == 1);
      check("rdata0", rdata0, m_last[0]);
      check("rdata1", rdata1, m_last[1]);
      // advance
      if (!hw) begin
        if (who >= 0) begin
          m_fav = 1 - who;
          if (m_cnt + 1 == MaxB) begin
            m_cnt = 0;
            m_owner = r[1 - who] ? 1 - who : who;
          end else begin
            m_cnt++;
            m_owner = who;
          end
        end else if (m_owner >= 0) begin
          m_cnt = 0;
          m_owner = r[1 - m_owner] ? 1 - m_owner : -1;
        end
      end
      m_pend = who;
      if (who >= 0) m_pdata = mem[a[who]];
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
`ifdef ARB_HOSTWR_EN
    host_we = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
`ifdef ARB_HOSTWR_EN
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
`endif
    tick(); tick();
    reset = 1'b0;
    mid();
    check("post_rst_rdata0", rdata0, 0);
    check("post_rst_mem_cs", mem_cs, 0);
    tick();

    // Single read of address 129 from idle: mem[129] = 129*7+3 mod 256 = 0x8A.
    req0 = 1'b1; addr0 = 14'd129;
    mid(); check("lat_gnt0", gnt0, 1); check("lat_addr", mem_addr, 129);
    tick(); req0 = 1'b0;
    mid(); check("lat_rvalid0", rvalid0, 1); check("lat_rdata0", rdata0, 8'h8A);
    tick();
    mid(); check("hold_rvalid0", rvalid0, 0); check("hold_rdata0", rdata0, 8'h8A);
    tick();
    // Last served was req0, so a tie now goes to req1.
    req0 = 1'b1; req1 = 1'b1; addr1 = 14'd77;
    mid(); check("rr_tie_gnt1", gnt1, 1); check("rr_tie_gnt0", gnt0, 0);
    tick(); req0 = 1'b0; req1 = 1'b0; tick(); tick();

    // Both held from reset: bursts of 9 alternate, starting with req0.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 14'd5; addr1 = 14'd200;
    for (int i = 0; i < 36; i++) begin
      mid();
      check("alt_gnt0", gnt0, ((i / 9) % 2) == 0);
      check("alt_gnt1", gnt1, ((i / 9) % 2) == 1);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; tick(); tick();

    // req0 alone: a grant every cycle through counter wrap.
    do_reset();
    req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      addr0 = 14'(i * 3 + 1000);
      mid(); check("solo_gnt0", gnt0, 1);
      tick();
    end
    req0 = 1'b0; tick(); tick();

    // req1 drops after 3 grants with req0 pending; req0's burst starts from zero.
    do_reset();
    req1 = 1'b1; addr1 = 14'd50;
    mid(); check("drop_g1_a", gnt1, 1); tick();
    req0 = 1'b1; addr0 = 14'd60;
    mid(); check("drop_g1_b", gnt1, 1); tick();
    mid(); check("drop_g1_c", gnt1, 1); tick();
    req1 = 1'b0;
    mid(); check("drop_gap_g0", gnt0, 0); check("drop_gap_g1", gnt1, 0); tick();
    req1 = 1'b1;
    for (int i = 0; i < MaxB; i++) begin
      mid(); check("drop_burst_g0", gnt0, 1); tick();
    end
    mid(); check("drop_switch_g1", gnt1, 1); tick();
    req0 = 1'b0; req1 = 1'b0; tick(); tick();

    // Reset clears the tie pointer: after serving req0 a tie would favour req1.
    do_reset();
    req0 = 1'b1; addr0 = 14'd9;
    mid(); check("rrrst_g0", gnt0, 1); tick();
    req0 = 1'b0; reset = 1'b1; tick();
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
    mid(); check("rrrst_tie_g0", gnt0, 1); tick();
    req0 = 1'b0; req1 = 1'b0; tick(); tick();

    // Reset the cycle after a req1 grant squashes its return.
    do_reset();
    req1 = 1'b1; addr1 = 14'd321;
    mid(); check("sq_gnt1", gnt1, 1); tick();
    req1 = 1'b0; reset = 1'b1;
    mid(); check("sq_rvalid1", rvalid1, 0); check("sq_rst_gnt1", gnt1, 0); tick();
    reset = 1'b0;
    mid(); check("sq_after_rvalid1", rvalid1, 0); check("sq_after_rdata1", rdata1, 0); tick();
    req0 = 1'b1; req1 = 1'b1;
    mid(); check("sq_tie_g0", gnt0, 1); check("sq_tie_g1", gnt1, 0); tick();
    req0 = 1'b0; req1 = 1'b0; tick(); tick();

`ifdef ARB_HOSTWR_EN
    // Host write collides with both requests from idle, then again at burst count 4.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 14'd300; addr1 = 14'd400;
    host_we = 1'b1; host_addr = 14'd16254; host_wdata = 8'h5A;
    mid();
    check("hw0_gnt0", gnt0, 0); check("hw0_gnt1", gnt1, 0);
    check("hw0_we", mem_we, 1); check("hw0_addr", mem_addr, 16254); check("hw0_wd", mem_wdata, 8'h5A);
    tick(); host_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid(); check("hw_pre_g0", gnt0, 1); tick();
    end
    host_we = 1'b1;
    mid(); check("hw4_gnt0", gnt0, 0); check("hw4_we", mem_we, 1); tick();
    host_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid(); check("hw_post_g0", gnt0, 1); tick();
    end
    mid(); check("hw_switch_g1", gnt1, 1); tick();
    req0 = 1'b0; req1 = 1'b0; tick(); tick();
    req0 = 1'b1; addr0 = 14'd16254;
    mid(); check("hw_rd_gnt0", gnt0, 1); tick();
    req0 = 1'b0;
    mid(); check("hw_rd_rvalid0", rvalid0, 1); check("hw_rd_rdata0", rdata0, 8'h5A); tick();
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_mem_arb.md
GRAY_MEM_ARB -- requirements
Module: gray_mem_arb

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all logic on rising edge; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have requester ports: req0/req1  in  1  read request, held with address until granted.
REQ-003 SHALL have: addr0/addr1  in  14  gray pixel address, {row[6:0],col[6:0]}.
REQ-004 SHALL have: gnt0/gnt1  out  1  combinational; address issued to memory this cycle.
REQ-005 SHALL have: rvalid0/rvalid1  out  1 and rdata0/rdata1  out  8  registered read return.
REQ-006 SHALL have memory ports: mem_cs  out  1; mem_we  out  1; mem_addr  out  14; mem_wdata  out  8; mem_rdata  in  8, valid the cycle after mem_cs.
REQ-007 SHALL have, when ARB_HOSTWR_EN is defined: host_we  in  1; host_addr  in  14; host_wdata  in  8.
REQ-008 SHALL have parameter: MAX_BURST, default 9, consecutive grants before forced rotation (one 3x3 window).

Function
REQ-009 SHALL implement states IDLE, OWN0, OWN1; a 4-bit burst counter; a 1-bit in-flight owner register plus in-flight valid.
REQ-010 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> the requester not last served (rr pointer, reset value 0 = favour req0).
REQ-011 OWNx: gntx=1 whenever reqx=1 and no host write in that cycle; counter increments per grant.
REQ-012 OWNx: reqx dropped -> other requester's OWN state if requesting, else IDLE; counter cleared.
REQ-013 OWNx: MAX_BURST-th grant given and other requester asserting -> switch to other OWN state next cycle; counter cleared, rr pointer updated.
REQ-014 OWNx: MAX_BURST reached with no competitor -> stay in OWNx, counter wraps to 0.
REQ-015 Arbitration decision in IDLE SHALL grant in the same cycle (zero-cycle idle latency); at most one gnt high per cycle.
REQ-016 Granted cycle: mem_cs=1, mem_we=0, mem_addr=addrx.
REQ-017 Read latency: rvalidx=1 with rdatax=mem_rdata exactly one cycle after gntx; other rvalid stays 0.
REQ-018 rdata0/rdata1 SHALL hold last value when rvalid is 0.
REQ-019 Host write (ARB_HOSTWR_EN) SHALL have absolute priority: mem_cs=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata; all gnt=0 that cycle; state and counter frozen.
REQ-020 Simultaneous req0, req1 and host_we: host served, then requester per REQ-010..013.
REQ-021 No request and no write: mem_cs=0, mem_addr=0, mem_wdata=0.

Reset
REQ-022 reset SHALL force state IDLE, counter 0, rr pointer 0, in-flight valid 0, rvalid0=rvalid1=0, rdata0=rdata1=0.
REQ-023 reset asserted the cycle after a grant SHALL suppress that read's rvalid; gnt outputs 0 while reset high.

Configuration
REQ-024 Macro ARB_HOSTWR_EN defined: host write port and priority per REQ-019 present.
REQ-025 ARB_HOSTWR_EN undefined: host ports absent, mem_we and mem_wdata tied 0, no cycle stealing.

Verification
REQ-026 req0=1 addr0=129 alone from IDLE -> gnt0 same cycle, mem_addr=129; next cycle rvalid0=1, rdata0=mem[129].
REQ-027 req0 and req1 both held from reset -> gnt0 for 9 cycles, then gnt1 for 9 cycles, alternating; never both high.
REQ-028 req0 held, req1 idle -> gnt0 every cycle for 20 cycles, counter wraps, no gap.
REQ-029 (ARB_HOSTWR_EN) host_we=1 addr=16254 data=0x5A during OWN0 burst at count 4 -> gnt0=0 that cycle, mem_we=1; burst resumes at count 4; later read of 16254 returns 0x5A.
REQ-030 reset pulsed one cycle after gnt1 -> rvalid1 stays 0; state IDLE; first post-reset tie goes to req0.
REQ-031 req1 drops after 3 grants while req0 pending -> gnt0 next cycle, counter restarts at 0.
